// File: rtl/aspiradora_scheduler.sv
// Mission scheduler for the robot vacuum. It arbitrates the start button,
// the dirt, obstacle and battery sensors and the dock contact, and times the
// cleaning and evasion bursts. It drives the registered on/cleaning/evading/
// return_home commands for the downstream vacuum state FSM.
module aspiradora_scheduler #(
    parameter int         EVADE_CYCLES = 8,
    parameter int         CLEAN_CYCLES = 16,
    parameter logic [7:0] BATT_LOW     = 8'd32,
    parameter logic [7:0] BATT_FULL    = 8'd240
) (
    input  logic       clk,
    input  logic       power_off,
    input  logic       start_btn,
    input  logic       dirt_det,
    input  logic       obstacle_det,
    input  logic [7:0] batt_level,
    input  logic       docked,
    output logic       on,
    output logic       cleaning,
    output logic       evading,
    output logic       return_home,
    output logic [2:0] state_o,
    output logic [7:0] clean_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXPLORE = 3'd1,
        EVADE   = 3'd2,
        CLEAN   = 3'd3,
        DOCK    = 3'd4,
        CHARGE  = 3'd5
    } state_t;

    // Timer reload values: the burst lasts LOAD+1 cycles because tmr=0 is
    // itself one cycle spent in the state.
    localparam logic [7:0] EVADE_LOAD = 8'(EVADE_CYCLES - 1);
    localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmr;
    logic [7:0] tmr_nxt;
    logic [7:0] count_nxt;
    logic       low;

    // Completed-burst counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign low     = (batt_level < BATT_LOW);
    assign state_o = state;

    // Next-state, shared timer and burst counter; cases are in priority order.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        count_nxt = clean_count;
        case (state)
            IDLE: begin
                if (start_btn && !low) state_nxt = EXPLORE;
            end
            EXPLORE: begin
                if (start_btn) begin
                    state_nxt = IDLE;
                end else if (low) begin
                    state_nxt = DOCK;
                end else if (obstacle_det) begin
                    state_nxt = EVADE;
                    tmr_nxt   = EVADE_LOAD;
                end else if (dirt_det) begin
                    state_nxt = CLEAN;
                    tmr_nxt   = CLEAN_LOAD;
                end
            end
            EVADE: begin
                if (tmr != 8'd0) begin
                    tmr_nxt = tmr - 8'd1;
                end else if (obstacle_det) begin
                    tmr_nxt = EVADE_LOAD;
                end else if (low) begin
                    state_nxt = DOCK;
                end else begin
                    state_nxt = EXPLORE;
                end
            end
            CLEAN: begin
                if (obstacle_det) begin
                    state_nxt = EVADE;
                    tmr_nxt   = EVADE_LOAD;
                end else if (low) begin
                    state_nxt = DOCK;
                end else if (start_btn) begin
                    state_nxt = IDLE;
                end else if (!dirt_det || tmr == 8'd0) begin
                    state_nxt = EXPLORE;
                    count_nxt = sat_inc(clean_count);
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            DOCK: begin
                if (docked) state_nxt = CHARGE;
            end
            CHARGE: begin
                if (batt_level >= BATT_FULL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, timer, counter and Moore outputs decoded from the next state so
    // the commands are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (power_off) begin
            state       <= IDLE;
            tmr         <= 8'd0;
            clean_count <= 8'd0;
            on          <= 1'b0;
            cleaning    <= 1'b0;
            evading     <= 1'b0;
            return_home <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            clean_count <= count_nxt;
            on          <= (state_nxt == EXPLORE) || (state_nxt == EVADE) ||
                           (state_nxt == CLEAN)   || (state_nxt == DOCK);
            cleaning    <= (state_nxt == CLEAN);
            evading     <= (state_nxt == EVADE) ||
                           ((state_nxt == DOCK) && obstacle_det);
            return_home <= (state_nxt == DOCK);
        end
    end

endmodule

// File: tb/tb_aspiradora_scheduler.sv
// Directed bench for aspiradora_scheduler: each stimulus cycle queues the
// hand-derived expected outputs, and a monitor process checks them after
// the clock edge.
module tb_aspiradora_scheduler;

    localparam logic [2:0] S_IDLE = 3'd0, S_EXP = 3'd1, S_EVD = 3'd2,
                           S_CLN = 3'd3, S_DOCK = 3'd4, S_CHG = 3'd5;
    // flags = {on, cleaning, evading, return_home}
    localparam logic [3:0] F_OFF = 4'b0000, F_EXP = 4'b1000, F_EVD = 4'b1010,
                           F_CLN = 4'b1100, F_DOCK = 4'b1001, F_DOCKO = 4'b1011;

    logic       clk = 1'b0;
    logic       power_off = 1'b1;
    logic       start_btn = 1'b0;
    logic       dirt_det = 1'b0;
    logic       obstacle_det = 1'b0;
    logic [7:0] batt_level = 8'd200;
    logic       docked = 1'b0;
    logic       on, cleaning, evading, return_home;
    logic [2:0] state_o;
    logic [7:0] clean_count;

    typedef struct {
        logic [2:0] st;
        logic [3:0] fl;
        logic [7:0] cnt;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   errors = 0;
    int   c;

    aspiradora_scheduler dut (
        .clk(clk), .power_off(power_off), .start_btn(start_btn),
        .dirt_det(dirt_det), .obstacle_det(obstacle_det),
        .batt_level(batt_level), .docked(docked), .on(on),
        .cleaning(cleaning), .evading(evading), .return_home(return_home),
        .state_o(state_o), .clean_count(clean_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic pw, input logic sb, input logic dt,
                        input logic ob, input logic [7:0] bt, input logic dk,
                        input logic [2:0] es, input logic [3:0] ef,
                        input logic [7:0] ec, input string nm);
        exp_t e;
        power_off    = pw;
        start_btn    = sb;
        dirt_det     = dt;
        obstacle_det = ob;
        batt_level   = bt;
        docked       = dk;
        e.st = es; e.fl = ef; e.cnt = ec; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the DUT against the queued expectation each cycle.
    initial begin
        exp_t e;
        logic [14:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                got  = {state_o, on, cleaning, evading, return_home, clean_count};
                want = {e.st, e.fl, e.cnt};
                tests++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got state=%0d flags=%b cnt=%0d, expected state=%0d flags=%b cnt=%0d",
                             e.nm, state_o, {on, cleaning, evading, return_home},
                             clean_count, e.st, e.fl, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, including a start press that must be overridden.
        step(1, 0, 0, 0, 200, 0, S_IDLE, F_OFF, 0, "reset0");
        step(1, 1, 0, 0, 200, 0, S_IDLE, F_OFF, 0, "reset_start");
        step(1, 0, 1, 1, 200, 1, S_IDLE, F_OFF, 0, "reset_inputs");
        step(0, 0, 0, 0, 200, 0, S_IDLE, F_OFF, 0, "idle_hold");
        step(0, 1, 0, 0, 200, 0, S_EXP,  F_EXP, 0, "start");
        step(0, 0, 0, 0, 200, 0, S_EXP,  F_EXP, 0, "explore_hold");

        // One-cycle obstacle: 8 cycles of EVADE then EXPLORE.
        step(0, 0, 0, 1, 200, 0, S_EVD, F_EVD, 0, "evade_enter");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 200, 0, S_EVD, F_EVD, 0, "evade_burst");
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 0, "evade_exit");

        // Obstacle held 20 cycles: 24 cycles of EVADE.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 200, 0, S_EVD, F_EVD, 0, "evade_held");
        for (int i = 0; i < 4; i++)  step(0, 0, 0, 0, 200, 0, S_EVD, F_EVD, 0, "evade_tail");
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 0, "evade_held_exit");

        // Dirt held: two full 16-cycle bursts, one EXPLORE cycle between.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 8'(b), "clean_burst");
            step(0, 0, 1, 0, 200, 0, S_EXP, F_EXP, 8'(b + 1), "clean_done");
        end
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 2, "no_dirt");

        // Obstacle at cycle 5 of CLEAN aborts without counting.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 2, "clean_pre_abort");
        step(0, 0, 1, 1, 200, 0, S_EVD, F_EVD, 2, "clean_abort");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 200, 0, S_EVD, F_EVD, 2, "abort_evade");
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 2, "abort_exit");

        // Dirt and obstacle together: EVADE wins.
        step(0, 0, 1, 1, 200, 0, S_EVD, F_EVD, 2, "dirt_obs_tie");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 200, 0, S_EVD, F_EVD, 2, "tie_evade");
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 2, "tie_exit");

        // Start and low together: IDLE wins; low start in IDLE ignored.
        step(0, 1, 0, 0, 31, 0, S_IDLE, F_OFF, 2, "start_low_tie");
        step(0, 1, 0, 0, 31, 0, S_IDLE, F_OFF, 2, "idle_low_start");
        step(0, 1, 0, 0, 32, 0, S_EXP,  F_EXP, 2, "start_at_thresh");

        // Low battery: DOCK, evading mirrors obstacle, CHARGE, back to IDLE.
        step(0, 0, 0, 0, 31, 0, S_DOCK, F_DOCK,  2, "low_dock");
        step(0, 0, 0, 1, 31, 0, S_DOCK, F_DOCKO, 2, "dock_obstacle");
        step(0, 1, 0, 0, 31, 0, S_DOCK, F_DOCK,  2, "dock_start_ign");
        step(0, 0, 0, 0, 31, 1, S_CHG,  F_OFF,   2, "charge");
        step(0, 0, 0, 0, 100, 0, S_CHG, F_OFF,   2, "charge_undock");
        step(0, 0, 0, 0, 239, 0, S_CHG, F_OFF,   2, "charge_239");
        step(0, 0, 0, 0, 240, 0, S_IDLE, F_OFF,  2, "charge_full");

        // Low during EVADE only takes effect at tmr=0.
        step(0, 1, 0, 0, 200, 0, S_EXP, F_EXP, 2, "restart");
        step(0, 0, 0, 1, 200, 0, S_EVD, F_EVD, 2, "evade_low_enter");
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 20, 0, S_EVD, F_EVD, 2, "evade_low_ign");
        step(0, 0, 0, 0, 20, 0, S_DOCK, F_DOCK, 2, "evade_low_dock");
        step(1, 0, 0, 0, 200, 0, S_IDLE, F_OFF, 0, "reset_dock");

        // Early dirt loss counts; power_off mid-CLEAN clears at count 3.
        step(0, 1, 0, 0, 200, 0, S_EXP, F_EXP, 0, "start2");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 8'(k), "short_clean");
            step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 8'(k + 1), "short_done");
        end
        step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 3, "clean_again");
        step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 3, "clean_mid");
        step(1, 0, 1, 0, 200, 0, S_IDLE, F_OFF, 0, "poweroff_mid");
        step(0, 0, 1, 0, 200, 0, S_IDLE, F_OFF, 0, "after_poweroff");

        // 256 completions saturate the counter at 255.
        step(0, 1, 0, 0, 200, 0, S_EXP, F_EXP, 0, "start3");
        c = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 1, 0, 200, 0, S_CLN, F_CLN, 8'(c), "sat_clean");
            if (c < 255) c++;
            step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 8'(c), "sat_done");
        end
        step(0, 0, 0, 0, 200, 0, S_EXP, F_EXP, 255, "sat_hold");

        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
